// File: rtl/regression_sample_sequencer.sv
// Sample store and two-pass replay sequencer for the linear-regression datapath.
// Optional build macro SEQ_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module regression_sample_sequencer #(
  parameter int W         = 20,
  parameter int N_SAMPLES = 150,
  parameter int AW        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_x,
  input  logic [W-1:0] s_y,
  output logic [W-1:0] x_bus,
  output logic [W-1:0] y_bus,
  output logic         mean_en,
  output logic         rst_temps,
  output logic         rst_means,
  output logic         load_temps,
  output logic         load_mean_x,
  output logic         load_mean_y,
  output logic         select_y,
  output logic         select_150,
  input  logic [W-1:0] beta0_in,
  input  logic [W-1:0] beta1_in,
  output logic [W-1:0] beta0,
  output logic [W-1:0] beta1,
  output logic         busy,
  output logic         done
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]  cycle_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLR, PASS1, MEAN_X, MEAN_Y, CLR2, PASS2, BETA, DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N_SAMPLES - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            we;
  logic [W-1:0]    beta0_q, beta1_q;
  logic [2*W-1:0]  mem [N_SAMPLES];
  logic [2*W-1:0]  rd_word;
  logic            replay;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        wr_d    = '0;
      end
      LOAD: if (s_valid) begin
        we = 1'b1;
        if (wr_q == LAST) begin
          wr_d    = '0;
          state_d = CLR;
        end else begin
          wr_d = wr_q + 1'b1;
        end
      end
      CLR: begin
        rd_d    = '0;
        state_d = PASS1;
      end
      PASS1: if (rd_q == LAST) begin
        rd_d    = '0;
        state_d = MEAN_X;
      end else begin
        rd_d = rd_q + 1'b1;
      end
      MEAN_X: state_d = MEAN_Y;
      MEAN_Y: state_d = CLR2;
      CLR2: begin
        rd_d    = '0;
        state_d = PASS2;
      end
      PASS2: if (rd_q == LAST) begin
        rd_d    = '0;
        state_d = BETA;
      end else begin
        rd_d = rd_q + 1'b1;
      end
      BETA:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each one is registered yet
  // aligned with the cycle its state occupies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      beta0_q     <= '0;
      beta1_q     <= '0;
      s_ready     <= 1'b0;
      mean_en     <= 1'b0;
      rst_temps   <= 1'b0;
      rst_means   <= 1'b0;
      load_temps  <= 1'b0;
      load_mean_x <= 1'b0;
      load_mean_y <= 1'b0;
      select_y    <= 1'b0;
      select_150  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      s_ready     <= (state_d == LOAD);
      mean_en     <= (state_d == PASS1);
      rst_temps   <= (state_d == CLR) || (state_d == CLR2);
      rst_means   <= (state_d == CLR);
      load_temps  <= (state_d == PASS1) || (state_d == PASS2);
      load_mean_x <= (state_d == MEAN_X);
      load_mean_y <= (state_d == MEAN_Y);
      select_y    <= (state_d == MEAN_Y) || (state_d == BETA);
      select_150  <= (state_d == MEAN_X) || (state_d == MEAN_Y);
      busy        <= state_d inside {CLR, PASS1, MEAN_X, MEAN_Y, CLR2, PASS2, BETA};
      done        <= (state_d == DONE);
      if (state_q == BETA) begin
        beta0_q <= beta0_in;
        beta1_q <= beta1_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_q] <= {s_x, s_y};
  end

  assign rd_word = mem[rd_q];
  assign replay  = (state_q == PASS1) || (state_q == PASS2);
  assign x_bus   = replay ? rd_word[2*W-1:W] : '0;
  assign y_bus   = replay ? rd_word[W-1:0]   : '0;
  assign beta0   = beta0_q;
  assign beta1   = beta1_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q <= '0;
    end else if (busy && cnt_q != '1) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_count = cnt_q;
`endif

endmodule
